// File: rtl/milspi_pkg.sv
// SPI-side framing constants, command codes and frame decoder states.
package milspi_pkg;

    localparam logic [15:0] ESC_WCOMMAND = 16'hFFA1;
    localparam logic [15:0] ESC_WDATA    = 16'hFFA3;

    localparam logic [7:0] CMD_RESET   = 8'hA0;
    localparam logic [7:0] CMD_SEND    = 8'hA2;
    localparam logic [7:0] CMD_STATUS  = 8'hB0;
    localparam logic [7:0] CMD_RECEIVE = 8'hB2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_WNUM,
        ST_DONE,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/milstd1553_pkg.sv
// MIL-STD-1553 word classification shared by the bridge's Mil-facing blocks.
package milstd1553_pkg;

    typedef enum logic [1:0] {
        WCOMMAND = 2'd1,
        WDATA    = 2'd2
    } word_type_t;

endpackage

// File: rtl/milspi_commit_fifo.sv
// Word buffer with a speculative write pointer: entries become readable only after
// commit, and an unfinished frame is discarded by rolling the write pointer back.
module milspi_commit_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [1:0]  i_wr_type,
    input  logic [15:0] i_wr_data,
    input  logic        i_commit,
    input  logic        i_rollback,
    input  logic        i_rd_en,
    output logic        o_full,
    output logic        o_rd_valid,
    output logic [1:0]  o_rd_type,
    output logic [15:0] o_rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [17:0] r_mem [DEPTH];
    logic        w_push, w_pop;
    logic [17:0] w_head;

    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_valid = (r_rd_ptr != r_commit_ptr);
    assign w_push     = i_wr_en && !o_full && !i_rollback;
    assign w_pop      = i_rd_en && o_rd_valid;
    assign w_head     = o_rd_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
    assign o_rd_type  = w_head[17:16];
    assign o_rd_data  = w_head[15:0];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {i_wr_type, i_wr_data};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (i_rollback)  r_wr_ptr <= r_commit_ptr;
            else if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_commit)    r_commit_ptr <= r_wr_ptr;
            if (w_pop)       r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/milspi_frame_decoder.sv
// Parses SPI packet framing, decodes send-to-Mil payloads into typed Mil words and
// releases them only once the frame checksum has been validated.
module milspi_frame_decoder
    import milstd1553_pkg::*;
    import milspi_pkg::*;
#(
    parameter logic [7:0] BLOCK_ADDR   = 8'hAB,
    parameter logic [7:0] CMD_MIL_SEND = CMD_SEND,
    parameter int         FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_frame,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_type,
    output logic [15:0] out_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [7:0]  cmd_size,
    output logic        frame_err
);
    state_t      r_state, w_state_next;
    logic [15:0] r_sum;
    logic [7:0]  r_size, r_cmd, r_count;
    logic        r_addr_ok, r_esc_pend, r_csum_ok;
    word_type_t  r_esc_type;
    logic        r_cmd_valid, r_frame_err;
    logic [7:0]  r_cmd_code, r_cmd_size;

    logic        w_wr_en, w_commit, w_reject, w_full, w_is_esc;
    word_type_t  w_wr_type;

    // An escape word only counts as one when it is not itself being escaped.
    assign w_is_esc = (r_cmd == CMD_MIL_SEND) && !r_esc_pend &&
                      ((in_data == ESC_WCOMMAND) || (in_data == ESC_WDATA));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_wr_type    = WDATA;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        if (!in_frame) begin
            w_state_next = ST_IDLE;
            if (r_state inside {ST_DATA, ST_CSUM, ST_WNUM}) w_reject = 1'b1;
        end else if (in_valid) begin
            case (r_state)
                ST_IDLE: w_state_next = ST_HDR;
                ST_HDR: begin
                    if (!r_addr_ok)                w_state_next = ST_SKIP;
                    else if (in_data[15:8] != '0)  w_state_next = ST_DATA;
                    else                           w_state_next = ST_CSUM;
                end
                ST_DATA: begin
                    if ((r_cmd == CMD_MIL_SEND) && !w_is_esc) begin
                        w_wr_en   = 1'b1;
                        w_wr_type = r_esc_pend ? r_esc_type : WDATA;
                    end
                    if (w_wr_en && w_full) begin
                        w_reject     = 1'b1;
                        w_state_next = ST_SKIP;
                    end else if (r_count == 8'd1) begin
                        w_reject     = w_is_esc;
                        w_state_next = w_is_esc ? ST_SKIP : ST_CSUM;
                    end
                end
                ST_CSUM: w_state_next = ST_WNUM;
                ST_WNUM: begin
                    w_state_next = ST_DONE;
                    w_commit     = r_csum_ok;
                    w_reject     = !r_csum_ok;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum       <= '0;
            r_size      <= '0;
            r_cmd       <= '0;
            r_count     <= '0;
            r_addr_ok   <= 1'b0;
            r_esc_pend  <= 1'b0;
            r_esc_type  <= WDATA;
            r_csum_ok   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_cmd_code  <= '0;
            r_cmd_size  <= '0;
        end else begin
            r_cmd_valid <= w_commit;
            r_frame_err <= w_reject;
            if (w_commit) begin
                r_cmd_code <= r_cmd;
                r_cmd_size <= r_size;
            end
            if (in_frame && in_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_sum      <= in_data;
                        r_addr_ok  <= (in_data[15:8] == BLOCK_ADDR);
                        r_esc_pend <= 1'b0;
                    end
                    ST_HDR: begin
                        r_sum   <= r_sum + in_data;
                        r_size  <= in_data[15:8];
                        r_cmd   <= in_data[7:0];
                        r_count <= in_data[15:8];
                    end
                    ST_DATA: begin
                        r_sum      <= r_sum + in_data;
                        r_count    <= r_count - 8'd1;
                        r_esc_pend <= w_is_esc;
                        if (w_is_esc) r_esc_type <= (in_data == ESC_WCOMMAND) ? WCOMMAND : WDATA;
                    end
                    ST_CSUM: r_csum_ok <= (in_data == r_sum);
                    default: ;
                endcase
            end
        end
    end

    milspi_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_type  (w_wr_type),
        .i_wr_data  (in_data),
        .i_commit   (w_commit),
        .i_rollback (w_reject),
        .i_rd_en    (out_ready),
        .o_full     (w_full),
        .o_rd_valid (out_valid),
        .o_rd_type  (out_type),
        .o_rd_data  (out_data)
    );

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_size  = r_cmd_size;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_milspi_frame_decoder.sv
// Bench for milspi_frame_decoder: directed frame table, hand-written corner sequences
// and randomized frames scored against a frame-level parsing model.
module tb_milspi_frame_decoder;
    import milstd1553_pkg::*;

    localparam logic [7:0] BLOCK_ADDR = 8'hAB;
    localparam logic [7:0] CMD_SEND   = 8'hA2;
    localparam int         DEPTH      = 16;

    logic        clk, rst;
    logic        in_frame, in_valid, out_ready;
    logic [15:0] in_data;
    logic        out_valid, cmd_valid, frame_err;
    logic [1:0]  out_type;
    logic [15:0] out_data;
    logic [7:0]  cmd_code, cmd_size;

    milspi_frame_decoder #(
        .BLOCK_ADDR   (BLOCK_ADDR),
        .CMD_MIL_SEND (CMD_SEND),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_frame  (in_frame),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_data  (out_data),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_size  (cmd_size),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts pulses and collects every completed output transfer.
    int          n_cmd, n_err;
    logic [7:0]  last_code, last_size;
    logic [17:0] got[$];

    always @(negedge clk) begin
        if (rst) begin
            if (cmd_valid) begin
                n_cmd++;
                last_code = cmd_code;
                last_size = cmd_size;
            end
            if (frame_err) n_err++;
            if (out_valid && out_ready) got.push_back({out_type, out_data});
        end
    end

    task automatic clear_mon();
        n_cmd = 0;
        n_err = 0;
        got.delete();
    endtask

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive_word(input logic [15:0] w);
        in_frame = 1'b1;
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] fr[$]);
        for (int i = 0; i < fr.size(); i++) drive_word(fr[i]);
        in_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        repeat (2) @(negedge clk);
        while (out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, " drained"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag, input bit e_cmd, input logic [7:0] e_code,
                           input logic [7:0] e_size, input bit e_err, input logic [17:0] e_out[$]);
        check({tag, " cmd_valid count"}, 32'(n_cmd), 32'(e_cmd));
        if (e_cmd) begin
            check({tag, " cmd_code"}, 32'(last_code), 32'(e_code));
            check({tag, " cmd_size"}, 32'(last_size), 32'(e_size));
        end
        check({tag, " frame_err count"}, 32'(n_err), 32'(e_err));
        check({tag, " word count"}, 32'(got.size()), 32'(e_out.size()));
        for (int i = 0; i < e_out.size() && i < got.size(); i++)
            check($sformatf("%s word %0d", tag, i), 32'(got[i]), 32'(e_out[i]));
    endtask

    // Frame-level reference: parse the whole frame with plain arithmetic.
    function automatic void model(input logic [15:0] fr[$], output bit e_cmd, output logic [7:0] e_code,
                                  output logic [7:0] e_size, output bit e_err, output logic [17:0] e_out[$]);
        logic [15:0] sum, d;
        logic [1:0]  pend_type, t;
        bit          pend;
        int          size;
        e_cmd = 1'b0;
        e_err = 1'b0;
        e_out.delete();
        e_size = fr[1][15:8];
        e_code = fr[1][7:0];
        if (fr[0][15:8] != BLOCK_ADDR) return;
        size      = int'(e_size);
        sum       = fr[0] + fr[1];
        pend      = 1'b0;
        pend_type = WDATA;
        for (int i = 0; i < size; i++) begin
            d = fr[2 + i];
            sum += d;
            if (e_code == CMD_SEND) begin
                if (!pend && (d == 16'hFFA1 || d == 16'hFFA3)) begin
                    pend      = 1'b1;
                    pend_type = (d == 16'hFFA1) ? WCOMMAND : WDATA;
                end else begin
                    t = pend ? pend_type : WDATA;
                    e_out.push_back({t, d});
                    pend = 1'b0;
                end
            end
        end
        if (pend || e_out.size() > DEPTH || fr[2 + size] != sum) begin
            e_err = 1'b1;
            e_out.delete();
        end else begin
            e_cmd = 1'b1;
        end
    endfunction

    // Directed vector table: frames and expected results held in shared pools.
    typedef struct packed {
        int         w_start;
        int         w_n;
        int         o_start;
        int         o_n;
        logic       exp_cmd;
        logic [7:0] exp_code;
        logic [7:0] exp_size;
        logic       exp_err;
    } vec_t;

    vec_t        vecs[$];
    vec_t        cur;
    logic [15:0] w_pool[$];
    logic [17:0] o_pool[$];
    logic [15:0] frame1 [10];

    task automatic vec_begin();
        cur.w_start = w_pool.size();
        cur.o_start = o_pool.size();
    endtask

    task automatic wp(input logic [15:0] w);
        w_pool.push_back(w);
    endtask

    task automatic op(input word_type_t t, input logic [15:0] d);
        o_pool.push_back({t, d});
    endtask

    task automatic vec_end(input logic e_cmd, input logic [7:0] e_code, input logic [7:0] e_size,
                           input logic e_err);
        cur.w_n      = w_pool.size() - cur.w_start;
        cur.o_n      = o_pool.size() - cur.o_start;
        cur.exp_cmd  = e_cmd;
        cur.exp_code = e_code;
        cur.exp_size = e_size;
        cur.exp_err  = e_err;
        vecs.push_back(cur);
    endtask

    initial begin
        logic [15:0] fr[$];
        logic [17:0] eo[$];
        logic [17:0] head_exp;

        rst       = 1'b0;
        in_frame  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        frame1 = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002,
                   16'hAB45, 16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};

        vec_begin();
        for (int i = 0; i < 10; i++) wp(frame1[i]);
        op(WCOMMAND, 16'h0001); op(WDATA, 16'h0002); op(WDATA, 16'hAB45); op(WDATA, 16'hFFA1);
        vec_end(1'b1, 8'hA2, 8'h06, 1'b0);

        vec_begin();
        wp(16'hAB00); wp(16'h0AB0);
        for (int i = 0; i < 10; i++) wp(16'h0000);
        wp(16'hB5B0); wp(16'h0000);
        vec_end(1'b1, 8'hB0, 8'h0A, 1'b0);

        vec_begin();
        wp(16'h0100); wp(16'h00A0); wp(16'h01A0); wp(16'h0000);
        vec_end(1'b0, 8'h00, 8'h00, 1'b0);

        vec_begin();
        for (int i = 0; i < 10; i++) wp((i == 8) ? 16'h5BCE : frame1[i]);
        vec_end(1'b0, 8'h00, 8'h00, 1'b1);

        vec_begin();
        wp(16'hAB00); wp(16'h11A2);
        for (int i = 1; i <= 17; i++) wp(16'(i));
        wp(16'hBD3B); wp(16'h0000);
        vec_end(1'b0, 8'h00, 8'h00, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_type",  32'(out_type),  32'd0);
        check("reset out_data",  32'(out_data),  32'd0);
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset cmd_code",  32'(cmd_code),  32'd0);
        check("reset cmd_size",  32'(cmd_size),  32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < vecs.size(); v++) begin
            fr.delete();
            eo.delete();
            for (int i = 0; i < vecs[v].w_n; i++) fr.push_back(w_pool[vecs[v].w_start + i]);
            for (int i = 0; i < vecs[v].o_n; i++) eo.push_back(o_pool[vecs[v].o_start + i]);
            clear_mon();
            run_frame(fr);
            drain($sformatf("vec%0d", v));
            compare($sformatf("vec%0d", v), vecs[v].exp_cmd, vecs[v].exp_code,
                    vecs[v].exp_size, vecs[v].exp_err, eo);
        end

        eo.delete();
        for (int i = 0; i < 4; i++) eo.push_back(o_pool[i]);

        // Aborted frame followed by an intact resend
        clear_mon();
        for (int i = 0; i < 6; i++) drive_word(frame1[i]);
        in_frame = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort frame_err count", 32'(n_err), 32'd1);
        check("abort cmd_valid count", 32'(n_cmd), 32'd0);
        check("abort word count", 32'(got.size()), 32'd0);
        clear_mon();
        fr.delete();
        for (int i = 0; i < 10; i++) fr.push_back(frame1[i]);
        run_frame(fr);
        drain("resend");
        compare("resend", 1'b1, 8'hA2, 8'h06, 1'b0, eo);

        // Backpressure: head word held stable, then released in order
        out_ready = 1'b0;
        clear_mon();
        run_frame(fr);
        head_exp = {WCOMMAND, 16'h0001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold head word", 32'({out_type, out_data}), 32'(head_exp));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("backpressure");
        compare("backpressure", 1'b1, 8'hA2, 8'h06, 1'b0, eo);

        // Reset in mid-frame wipes committed words too
        out_ready = 1'b0;
        run_frame(fr);
        @(negedge clk);
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive_word(frame1[i]);
        rst      = 1'b0;
        in_frame = 1'b0;
        @(negedge clk);
        check("mid-reset out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        check("post-reset word count", 32'(got.size()), 32'd0);
        check("post-reset frame_err count", 32'(n_err), 32'd0);
        @(posedge clk);
        #1;

        // Randomized frames against the frame-level model
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [15:0] sum;
            logic [7:0]  code, addr, e_code, e_size;
            int          size;
            bit          e_cmd, e_err;
            fr.delete();
            addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BLOCK_ADDR;
            case ($urandom_range(0, 3))
                0, 1:    code = CMD_SEND;
                2:       code = 8'hB0;
                default: code = 8'($urandom);
            endcase
            size = $urandom_range(0, 20);
            fr.push_back({addr, 8'($urandom)});
            fr.push_back({8'(size), code});
            for (int i = 0; i < size; i++) begin
                case ($urandom_range(0, 9))
                    0, 1:    fr.push_back(16'hFFA1);
                    2:       fr.push_back(16'hFFA3);
                    default: fr.push_back(16'($urandom));
                endcase
            end
            sum = '0;
            foreach (fr[i]) sum += fr[i];
            if ($urandom_range(0, 4) == 0) sum = sum ^ 16'(1 << $urandom_range(0, 15));
            fr.push_back(sum);
            fr.push_back(16'($urandom));
            model(fr, e_cmd, e_code, e_size, e_err, eo);
            clear_mon();
            run_frame(fr);
            drain($sformatf("rand%0d", f));
            compare($sformatf("rand%0d", f), e_cmd, e_code, e_size, e_err, eo);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
